wide_add_sequencer: RTL and testbench
=====================================

# wide_add_sequencer

Operand sequencer and result collector for the 128-bit registered carry-select adder. It assembles operands A and B from a narrow W-bit valid/ready input stream and drives them in parallel into the adder. It waits the adder's fixed pipeline latency, captures sum and carry-out, and streams the sum back out as W-bit beats. It sits directly around the adder: its add_a/add_b outputs feed the adder inputs, and its add_sum/add_cout inputs consume the adder's registered outputs.

## Interface
- MAX, 128: operand/sum width; must be a multiple of W.
- W, 32: stream beat width; N = MAX/W beats per operand.
- ADD_LAT, 2: adder latency, in clock edges, from a stable operand to registered sum/cout.

Ports:
- clk  in  1  single clock, rising-edge.
- rst_n  in  1  asynchronous, active-low reset.
- in_valid  in  1  input beat valid.
- in_ready  out  1  sequencer accepts an input beat.
- in_data  in  W  operand beat; least-significant beat first.
- out_valid  out  1  result beat valid.
- out_ready  in  1  downstream accepts a result beat.
- out_data  out  W  sum beat; least-significant beat first.
- out_last  out  1  high on the final (N-1) sum beat.
- out_cout  out  1  captured adder carry-out; held for all of SEND.
- add_a  out  MAX  operand A to the adder; registered.
- add_b  out  MAX  operand B to the adder; registered.
- add_sum  in  MAX  adder registered sum.
- add_cout  in  1  adder registered carry-out. The adder's p0 output is not consumed.

## Operation
- FSM states: LOAD_A, LOAD_B, WAIT, SEND. Beat counter width is clog2(N); latency counter width is clog2(ADD_LAT+1).
- Handshake: a beat transfers on a rising edge where valid && ready. Payload is stable while valid && !ready.
- LOAD_A: in_ready=1. Each transfer writes in_data to add_a[beat*W +: W], then beat++. The transfer at beat==N-1 sets beat=0 and moves to LOAD_B.
- LOAD_B: same behaviour into add_b. The last transfer moves to WAIT and loads lat_cnt=ADD_LAT.
- WAIT: in_ready=0. add_a/add_b are held. lat_cnt decrements each cycle. On the edge where lat_cnt==0: result<=add_sum, cout_r<=add_cout, beat=0, move to SEND.
- SEND: out_valid=1, out_data=result[beat*W +: W], out_last=(beat==N-1), out_cout=cout_r. On each transfer, beat++. The transfer at beat==N-1 moves to LOAD_A with beat=0.
- Arithmetic is unsigned modulo 2^MAX. Overflow appears only on out_cout. The sequencer performs no addition itself.
- add_a/add_b hold their last values in every state except during their own load. They are never cleared between operations except by reset.

## Timing
- Reset (rst_n low, asynchronous), all outputs forced immediately:
  - state=LOAD_A, beat=0, lat_cnt=0.
  - add_a=0, add_b=0, result=0, cout_r=0.
  - in_ready=1, out_valid=0, out_data=0, out_last=0, out_cout=0.
- Reset mid-operation discards partial operands and any unsent result. No out_valid follows.
- Let E0 be the edge accepting the last B beat. WAIT occupies ADD_LAT+1 cycles, and capture happens at edge E0+ADD_LAT+1. out_valid is high in the cycle after that edge.
- Minimum operation length is 2N + (ADD_LAT+1) + N cycles. in_ready rises in the cycle after the last out transfer; there are no bubbles beyond this.
- in_valid while in_ready=0 (WAIT/SEND) is ignored, and no data is written.
- out_ready high while out_valid=0 is ignored. out_ready held low stalls SEND indefinitely with outputs stable.
- in_valid gaps during LOAD_A/LOAD_B simply pause the beat counter.

## Test plan
- Reset: pulse rst_n low mid-LOAD_B, asynchronous to clk.
  - Required: all outputs take their reset values immediately, in_ready=1.
  - Then load A=5, B=7 (beats 5,0,0,0 / 7,0,0,0): out beats 12,0,0,0, out_cout=0.
- Full carry ripple: A beats FFFFFFFF×4, B beats 1,0,0,0 -> out beats 0,0,0,0, out_cout=1, out_last only on the 4th beat.
- Cross-beat carry: A beats FFFFFFFF,FFFFFFFF,FFFFFFFF,0 and B beats 1,0,0,0 -> out beats 0,0,0,1, out_cout=0.
- Latency check: with continuous in_valid and out_ready=1, out_valid rises exactly ADD_LAT+1 cycles after the E0 edge. in_ready is 0 throughout WAIT/SEND, and beats driven then are dropped.
- Backpressure:
  - Randomly toggle in_valid and out_ready over 1000 random A/B pairs.
  - Compare against an (A+B) mod 2^128 model and its carry.
  - out_data must stay stable while stalled.
- Back-to-back: two operations with no idle. in_ready rises the cycle after the first operation's last out beat, and the second result is correct.

Source files
------------

// File: rtl/wide_add_sequencer.sv
// wide_add_sequencer: gathers two MAX-bit operands from a W-bit valid/ready
// stream and holds them on add_a/add_b for an external registered adder.
// After the adder latency it captures sum/carry and returns the sum as W-bit
// beats, least-significant beat first.
//
// Ports:
//   clk, rst_n              clock, asynchronous active-low reset
//   in_valid/in_ready/in_data   operand beat stream (A beats, then B beats)
//   out_valid/out_ready/out_data/out_last/out_cout   sum beat stream
//   add_a, add_b            operands driven into the adder (registered)
//   add_sum, add_cout       registered adder result
module wide_add_sequencer #(
    parameter int unsigned MAX     = 128,
    parameter int unsigned W       = 32,
    parameter int unsigned ADD_LAT = 2
) (
    input  logic           clk,
    input  logic           rst_n,
    input  logic           in_valid,
    output logic           in_ready,
    input  logic [W-1:0]   in_data,
    output logic           out_valid,
    input  logic           out_ready,
    output logic [W-1:0]   out_data,
    output logic           out_last,
    output logic           out_cout,
    output logic [MAX-1:0] add_a,
    output logic [MAX-1:0] add_b,
    input  logic [MAX-1:0] add_sum,
    input  logic           add_cout
);

    localparam int unsigned N  = MAX / W;
    localparam int unsigned BW = (N > 1) ? $clog2(N) : 1;
    localparam int unsigned LW = (ADD_LAT > 0) ? $clog2(ADD_LAT + 1) : 1;

    localparam logic [BW-1:0] LAST_BEAT = BW'(N - 1);
    localparam logic [LW-1:0] LAT_INIT  = LW'(ADD_LAT);

    typedef enum logic [1:0] {
        LOAD_A,
        LOAD_B,
        WAIT,
        SEND
    } state_t;

    state_t         state, state_n;
    logic [BW-1:0]  beat, beat_n;
    logic [LW-1:0]  lat_cnt, lat_n;
    logic [MAX-1:0] a_n, b_n;
    logic [MAX-1:0] result, result_n;
    logic           cout_r, cout_n;

    logic           in_ready_n;
    logic           out_valid_n;
    logic [W-1:0]   out_data_n;
    logic           out_last_n;
    logic           out_cout_n;

    logic           in_fire;
    logic           out_fire;

    // in_ready/out_valid are registered copies of the state decode
    assign in_fire  = in_valid && in_ready;
    assign out_fire = out_valid && out_ready;

    // State, datapath and registered outputs
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= LOAD_A;
            beat      <= '0;
            lat_cnt   <= '0;
            add_a     <= '0;
            add_b     <= '0;
            result    <= '0;
            cout_r    <= 1'b0;
            in_ready  <= 1'b1;
            out_valid <= 1'b0;
            out_data  <= '0;
            out_last  <= 1'b0;
            out_cout  <= 1'b0;
        end else begin
            state     <= state_n;
            beat      <= beat_n;
            lat_cnt   <= lat_n;
            add_a     <= a_n;
            add_b     <= b_n;
            result    <= result_n;
            cout_r    <= cout_n;
            in_ready  <= in_ready_n;
            out_valid <= out_valid_n;
            out_data  <= out_data_n;
            out_last  <= out_last_n;
            out_cout  <= out_cout_n;
        end
    end

    // Next-state, datapath updates and next output values
    always_comb begin
        state_n  = state;
        beat_n   = beat;
        lat_n    = lat_cnt;
        a_n      = add_a;
        b_n      = add_b;
        result_n = result;
        cout_n   = cout_r;

        case (state)
            LOAD_A: begin
                if (in_fire) begin
                    a_n[beat*W +: W] = in_data;
                    if (beat == LAST_BEAT) begin
                        beat_n  = '0;
                        state_n = LOAD_B;
                    end else begin
                        beat_n = beat + BW'(1);
                    end
                end
            end
            LOAD_B: begin
                if (in_fire) begin
                    b_n[beat*W +: W] = in_data;
                    if (beat == LAST_BEAT) begin
                        beat_n  = '0;
                        lat_n   = LAT_INIT;
                        state_n = WAIT;
                    end else begin
                        beat_n = beat + BW'(1);
                    end
                end
            end
            WAIT: begin
                // Capture one edge after the counter reaches zero so the
                // adder has seen stable operands for ADD_LAT edges.
                if (lat_cnt == '0) begin
                    result_n = add_sum;
                    cout_n   = add_cout;
                    beat_n   = '0;
                    state_n  = SEND;
                end else begin
                    lat_n = lat_cnt - LW'(1);
                end
            end
            SEND: begin
                if (out_fire) begin
                    if (beat == LAST_BEAT) begin
                        beat_n  = '0;
                        state_n = LOAD_A;
                    end else begin
                        beat_n = beat + BW'(1);
                    end
                end
            end
            default: begin
                state_n = LOAD_A;
                beat_n  = '0;
            end
        endcase

        // Outputs follow the next state so they are valid in the same cycle
        in_ready_n  = (state_n == LOAD_A) || (state_n == LOAD_B);
        out_valid_n = (state_n == SEND);
        out_data_n  = '0;
        out_last_n  = 1'b0;
        out_cout_n  = 1'b0;
        if (state_n == SEND) begin
            out_data_n = result_n[beat_n*W +: W];
            out_last_n = (beat_n == LAST_BEAT);
            out_cout_n = cout_n;
        end
    end

endmodule

// File: tb/tb_wide_add_sequencer.sv
// Testbench for wide_add_sequencer: wraps the DUT around a behavioural
// pipelined adder and checks results against (A+B) mod 2^MAX plus carry.
module tb_wide_add_sequencer;

    localparam int unsigned MAX     = 128;
    localparam int unsigned W       = 32;
    localparam int unsigned ADD_LAT = 2;
    localparam int unsigned N       = MAX / W;

    logic           clk = 1'b0;
    logic           rst_n;
    logic           in_valid;
    logic           in_ready;
    logic [W-1:0]   in_data;
    logic           out_valid;
    logic           out_ready;
    logic [W-1:0]   out_data;
    logic           out_last;
    logic           out_cout;
    logic [MAX-1:0] add_a;
    logic [MAX-1:0] add_b;
    logic [MAX-1:0] add_sum;
    logic           add_cout;

    int checks = 0;
    int errors = 0;
    int cyc    = 0;

    wide_add_sequencer #(.MAX(MAX), .W(W), .ADD_LAT(ADD_LAT)) dut (
        .clk(clk), .rst_n(rst_n),
        .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
        .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
        .out_last(out_last), .out_cout(out_cout),
        .add_a(add_a), .add_b(add_b), .add_sum(add_sum), .add_cout(add_cout)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc++;

    // Behavioural adder: registered sum, ADD_LAT edges after stable operands
    logic [MAX:0] pipe [ADD_LAT];
    always @(posedge clk) begin
        pipe[0] <= {1'b0, add_a} + {1'b0, add_b};
        for (int i = 1; i < ADD_LAT; i++) pipe[i] <= pipe[i-1];
    end
    assign add_sum  = pipe[ADD_LAT-1][MAX-1:0];
    assign add_cout = pipe[ADD_LAT-1][MAX];

    // Operands for the next run and everything observed during it
    logic [MAX-1:0] a_q[$];
    logic [MAX-1:0] b_q[$];
    logic [W-1:0]   obs_data[$];
    bit             obs_last[$];
    bit             obs_cout[$];
    int             lat_meas[$];
    int             stall_changes, hold_errs, rdy_errs, bubble_errs;
    bit             timed_out;

    // Streams all queued operands through the DUT and records outputs.
    task automatic run_ops(input int nops, input int pv_pct, input int pr_pct);
        int in_op = 0, in_beat = 0, out_op = 0, out_beat = 0, cyc_e0 = 0, guard = 0;
        bit busy = 0, rise_pend = 0, last_fired = 0, stalled = 0, in_hold = 0;
        logic [W-1:0]   held = '0;
        logic [MAX-1:0] opnd;
        obs_data.delete(); obs_last.delete(); obs_cout.delete(); lat_meas.delete();
        stall_changes = 0; hold_errs = 0; rdy_errs = 0; bubble_errs = 0; timed_out = 0;
        while (!(out_op == nops && !last_fired)) begin
            @(negedge clk);
            guard++;
            if (guard > 100 * nops + 100) begin
                timed_out = 1;
                break;
            end
            if (busy) begin
                if (in_ready !== 1'b0) rdy_errs++;
                if (add_a !== a_q[out_op] || add_b !== b_q[out_op]) hold_errs++;
            end
            if (rise_pend && out_valid === 1'b1) begin
                lat_meas.push_back(cyc - cyc_e0);
                rise_pend = 0;
            end
            if (last_fired) begin
                if (in_ready !== 1'b1) bubble_errs++;
                last_fired = 0;
            end
            if (stalled && out_data !== held) stall_changes++;
            stalled = 0;

            if (in_op < nops) begin
                if (!in_hold) begin
                    in_valid = ($urandom_range(99) < pv_pct);
                    opnd     = (in_beat < N) ? a_q[in_op] : b_q[in_op];
                    in_data  = opnd[(in_beat % N)*W +: W];
                end
                in_hold = in_valid && !in_ready;
                if (in_valid && in_ready) begin
                    if (in_beat == 2*N-1) begin
                        busy = 1; rise_pend = 1; cyc_e0 = cyc + 1;
                        in_beat = 0; in_op++;
                    end else begin
                        in_beat++;
                    end
                end
            end else begin
                in_valid = 1'b0;
                in_data  = $urandom;
            end

            out_ready = ($urandom_range(99) < pr_pct);
            if (out_valid === 1'b1) begin
                if (out_ready) begin
                    obs_data.push_back(out_data);
                    obs_last.push_back(out_last);
                    obs_cout.push_back(out_cout);
                    if (out_beat == N-1) begin
                        out_beat = 0; out_op++; busy = 0; last_fired = 1;
                    end else begin
                        out_beat++;
                    end
                end else begin
                    stalled = 1;
                    held    = out_data;
                end
            end
        end
        in_valid  = 1'b0;
        out_ready = 1'b0;
    endtask

    task automatic test_reset();
        logic [MAX:0] s;
        rst_n = 1'b1; in_valid = 1'b0; out_ready = 1'b0; in_data = '0;
        #2 rst_n = 1'b0;
        repeat (3) @(negedge clk);
        checks++;
        if (in_ready !== 1'b1 || out_valid !== 1'b0 || out_data !== '0 || out_last !== 1'b0
            || out_cout !== 1'b0 || add_a !== '0 || add_b !== '0) begin
            errors++;
            $display("FAIL reset_init rdy=%0b vld=%0b data=%h last=%0b cout=%0b a=%h b=%h",
                     in_ready, out_valid, out_data, out_last, out_cout, add_a, add_b);
        end
        rst_n = 1'b1;
        // Load all of A and half of B, then reset between clock edges
        for (int i = 0; i < N + 2; i++) begin
            @(negedge clk);
            in_valid = 1'b1;
            in_data  = $urandom | 32'h1;
        end
        @(negedge clk);
        in_valid = 1'b0;
        #3 rst_n = 1'b0;
        #1;
        checks++;
        if (in_ready !== 1'b1 || out_valid !== 1'b0 || out_data !== '0 || out_last !== 1'b0
            || out_cout !== 1'b0) begin
            errors++;
            $display("FAIL reset_async_ctl rdy=%0b vld=%0b data=%h last=%0b cout=%0b exp 1/0/0/0/0",
                     in_ready, out_valid, out_data, out_last, out_cout);
        end
        checks++;
        if (add_a !== '0 || add_b !== '0) begin
            errors++;
            $display("FAIL reset_async_opnd a=%h b=%h exp 0", add_a, add_b);
        end
        @(negedge clk);
        rst_n = 1'b1;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            checks++;
            if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
                errors++;
                $display("FAIL reset_idle vld=%0b rdy=%0b exp 0/1", out_valid, in_ready);
            end
        end
        a_q = '{128'd5};
        b_q = '{128'd7};
        run_ops(1, 100, 100);
        checks++;
        if (timed_out || obs_data.size() != N) begin
            errors++;
            $display("FAIL reset_5p7_beats got=%0d exp=%0d", obs_data.size(), N);
        end else begin
            for (int i = 0; i < N; i++) begin
                checks++;
                if (obs_data[i] !== ((i == 0) ? 32'd12 : 32'd0) || obs_cout[i] !== 1'b0) begin
                    errors++;
                    $display("FAIL reset_5p7 beat%0d data=%h cout=%0b", i, obs_data[i], obs_cout[i]);
                end
            end
        end
        s = '0; // keep declared model variable used
        if (s !== '0) errors++;
    endtask

    task automatic test_carry_ripple();
        a_q = '{{MAX{1'b1}}};
        b_q = '{128'd1};
        run_ops(1, 100, 100);
        checks++;
        if (timed_out || obs_data.size() != N) begin
            errors++;
            $display("FAIL ripple_beats got=%0d exp=%0d", obs_data.size(), N);
        end else begin
            for (int i = 0; i < N; i++) begin
                checks++;
                if (obs_data[i] !== 32'd0 || obs_cout[i] !== 1'b1 || obs_last[i] !== (i == N-1)) begin
                    errors++;
                    $display("FAIL ripple beat%0d data=%h cout=%0b last=%0b exp 0/1/%0b",
                             i, obs_data[i], obs_cout[i], obs_last[i], i == N-1);
                end
            end
        end
    endtask

    task automatic test_cross_beat();
        logic [W-1:0] exp_b [N];
        exp_b = '{32'd0, 32'd0, 32'd0, 32'd1};
        a_q = '{{32'h0, {96{1'b1}}}};
        b_q = '{128'd1};
        run_ops(1, 100, 100);
        checks++;
        if (timed_out || obs_data.size() != N) begin
            errors++;
            $display("FAIL cross_beats got=%0d exp=%0d", obs_data.size(), N);
        end else begin
            for (int i = 0; i < N; i++) begin
                checks++;
                if (obs_data[i] !== exp_b[i] || obs_cout[i] !== 1'b0) begin
                    errors++;
                    $display("FAIL cross beat%0d data=%h exp=%h cout=%0b",
                             i, obs_data[i], exp_b[i], obs_cout[i]);
                end
            end
        end
    endtask

    task automatic test_latency();
        logic [MAX:0] s;
        a_q.delete(); b_q.delete();
        for (int k = 0; k < 3; k++) begin
            a_q.push_back({$urandom, $urandom, $urandom, $urandom});
            b_q.push_back({$urandom, $urandom, $urandom, $urandom});
        end
        run_ops(3, 100, 100);
        checks++;
        if (timed_out || lat_meas.size() != 3 || obs_data.size() != 3*N) begin
            errors++;
            $display("FAIL latency_run timeout=%0b lat=%0d beats=%0d", timed_out,
                     lat_meas.size(), obs_data.size());
        end else begin
            for (int k = 0; k < 3; k++) begin
                checks++;
                if (lat_meas[k] != ADD_LAT + 1) begin
                    errors++;
                    $display("FAIL latency op%0d got=%0d exp=%0d", k, lat_meas[k], ADD_LAT + 1);
                end
                s = {1'b0, a_q[k]} + {1'b0, b_q[k]};
                for (int i = 0; i < N; i++) begin
                    checks++;
                    if (obs_data[k*N+i] !== W'(s >> (i*W)) || obs_cout[k*N+i] !== s[MAX]) begin
                        errors++;
                        $display("FAIL latency_sum op%0d beat%0d data=%h exp=%h",
                                 k, i, obs_data[k*N+i], W'(s >> (i*W)));
                    end
                end
            end
        end
        checks++;
        if (rdy_errs != 0 || hold_errs != 0) begin
            errors++;
            $display("FAIL latency_drop rdy_errs=%0d hold_errs=%0d exp 0/0", rdy_errs, hold_errs);
        end
    endtask

    task automatic test_backpressure();
        localparam int NOPS = 1000;
        logic [MAX:0] s;
        int bad = 0;
        a_q.delete(); b_q.delete();
        for (int k = 0; k < NOPS; k++) begin
            a_q.push_back({$urandom, $urandom, $urandom, $urandom});
            b_q.push_back(($urandom_range(3) == 0) ? ~a_q[k] + 128'($urandom_range(2))
                                                    : {$urandom, $urandom, $urandom, $urandom});
        end
        run_ops(NOPS, 70, 60);
        checks++;
        if (timed_out || obs_data.size() != NOPS*N) begin
            errors++;
            $display("FAIL bp_beats timeout=%0b got=%0d exp=%0d", timed_out, obs_data.size(), NOPS*N);
        end else begin
            for (int k = 0; k < NOPS; k++) begin
                s = {1'b0, a_q[k]} + {1'b0, b_q[k]};
                for (int i = 0; i < N; i++) begin
                    checks++;
                    if (obs_data[k*N+i] !== W'(s >> (i*W)) || obs_cout[k*N+i] !== s[MAX]
                        || obs_last[k*N+i] !== (i == N-1)) begin
                        errors++;
                        if (bad < 10)
                            $display("FAIL bp_sum op%0d beat%0d data=%h exp=%h cout=%0b exp=%0b",
                                     k, i, obs_data[k*N+i], W'(s >> (i*W)), obs_cout[k*N+i], s[MAX]);
                        bad++;
                    end
                end
            end
        end
        checks++;
        if (stall_changes != 0 || hold_errs != 0 || rdy_errs != 0 || bubble_errs != 0) begin
            errors++;
            $display("FAIL bp_protocol stall=%0d hold=%0d rdy=%0d bubble=%0d exp 0",
                     stall_changes, hold_errs, rdy_errs, bubble_errs);
        end
        checks++;
        if (lat_meas.size() != NOPS) begin
            errors++;
            $display("FAIL bp_latcount got=%0d exp=%0d", lat_meas.size(), NOPS);
        end else begin
            foreach (lat_meas[k]) if (lat_meas[k] != ADD_LAT + 1) bad++;
            if (bad != 0) begin
                errors++;
                $display("FAIL bp_latency bad_ops=%0d exp=0", bad);
            end
        end
    endtask

    task automatic test_back_to_back();
        logic [MAX:0] s;
        int start;
        a_q = '{{$urandom, $urandom, $urandom, $urandom}, {MAX{1'b1}}};
        b_q = '{{$urandom, $urandom, $urandom, $urandom}, 128'd2};
        start = cyc;
        run_ops(2, 100, 100);
        checks++;
        if (timed_out || obs_data.size() != 2*N) begin
            errors++;
            $display("FAIL b2b_beats got=%0d exp=%0d", obs_data.size(), 2*N);
        end else begin
            for (int k = 0; k < 2; k++) begin
                s = {1'b0, a_q[k]} + {1'b0, b_q[k]};
                for (int i = 0; i < N; i++) begin
                    checks++;
                    if (obs_data[k*N+i] !== W'(s >> (i*W)) || obs_cout[k*N+i] !== s[MAX]) begin
                        errors++;
                        $display("FAIL b2b_sum op%0d beat%0d data=%h exp=%h",
                                 k, i, obs_data[k*N+i], W'(s >> (i*W)));
                    end
                end
            end
        end
        checks++;
        if (bubble_errs != 0) begin
            errors++;
            $display("FAIL b2b_in_ready bubble_errs=%0d exp=0", bubble_errs);
        end
        // Two minimum-length operations plus the idle check cycle after
        checks++;
        if (cyc - start != 2 * (3*N + ADD_LAT + 1) + 1) begin
            errors++;
            $display("FAIL b2b_cycles got=%0d exp=%0d", cyc - start, 2 * (3*N + ADD_LAT + 1) + 1);
        end
    endtask

    initial begin
        test_reset();
        test_carry_ripple();
        test_cross_beat();
        test_latency();
        test_backpressure();
        test_back_to_back();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
